// File: rtl/vec_sel_writer.sv
// Scatters bits into a 1-bit-per-element array through a runtime index, either one element
// per request or as a wrapping burst of a whole packed word; the packed mirror shares the storage.
module vec_sel_writer #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_mode,
  input  logic [IDXW-1:0]   wr_sel,
  input  logic              wr_bit,
  input  logic [DEPTH-1:0]  wr_word,
  output logic              mem_unp [DEPTH-1:0],
  output logic [DEPTH-1:0]  mem_pk,
  output logic              busy,
  output logic              done,
  output logic [7:0]        wr_count,
  output logic              err
);

  localparam int RW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    FIN     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] word_q, word_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept_s;

  function automatic logic in_range(input logic [IDXW-1:0] sel);
    return (int'(sel) < DEPTH);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'd255) ? 8'd255 : cnt + 8'd1;
  endfunction

  // Burst index wraps at DEPTH, which may be smaller than the index space.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    return (idx == IDXW'(DEPTH - 1)) ? '0 : idx + IDXW'(1);
  endfunction

  assign wr_ready = (state_q == IDLE) && !rst;
  assign accept_s = wr_valid && wr_ready;

  // Next-state and datapath updates for the request FSM
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    word_d  = word_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (!in_range(wr_sel)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = wr_mode ? FIN : IDLE;
        end else if (!wr_mode) begin
          mem_d[wr_sel] = wr_bit;
          cnt_d         = sat_inc(cnt_q);
          done_d        = 1'b1;
        end else begin
          word_d  = wr_word;
          idx_d   = wr_sel;
          rem_d   = RW'(DEPTH);
          state_d = SCATTER;
        end
      end
      SCATTER: begin
        mem_d[idx_q] = word_q[idx_q];
        cnt_d        = sat_inc(cnt_q);
        idx_d        = next_idx(idx_q);
        rem_d        = rem_q - RW'(1);
        if (rem_q == RW'(1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          state_d = SCATTER;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_unp
    assign mem_unp[k] = mem_q[k];
  end

  assign mem_pk   = mem_q;
  assign busy     = (state_q == SCATTER);
  assign done     = done_q;
  assign wr_count = cnt_q;
  assign err      = err_q;

endmodule
